// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder slice.
//   MW_* : request store-type encodings (req_wtype); 2'b11 behaves as a read
//   LT_* : load-format encodings (req_ltype); 2'b11 behaves as a word load
//   memstate_t : responder FSM states, numbered as shown on state_o
package mips_mem_pkg;

    localparam logic [1:0] MW_NONE  = 2'b00;
    localparam logic [1:0] MW_WORD  = 2'b01;
    localparam logic [1:0] MW_BYTE  = 2'b10;

    localparam logic [1:0] LT_WORD  = 2'b00;
    localparam logic [1:0] LT_BYTEU = 2'b01;
    localparam logic [1:0] LT_BYTES = 2'b10;

    // Wait counter width; holds LATENCY-1 for LATENCY in 1..15
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memstate_t;

    // Anything that is not SW or SB is executed as a load
    function automatic logic is_load(input logic [1:0] wtype);
        return !(wtype == MW_WORD || wtype == MW_BYTE);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle controller (master) and the
// memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_addr            : byte address
//   req_wtype/req_ltype : store type / load format
//   req_wdata           : store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : load result / misaligned-word flag
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_wtype;
    logic [1:0]  req_ltype;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, req_wtype, req_ltype, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wtype, req_ltype, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_responder_load_align.sv
// Combinational byte-lane logic for the responder (little-endian lanes).
//   word       in  : RAM word being accessed
//   lane       in  : byte address bits [1:0]
//   ltype      in  : load format (word / zero-extended byte / sign-extended byte)
//   store_byte in  : byte to insert for SB
//   load_data  out : formatted load result
//   merged     out : word with store_byte placed in the addressed lane
module mem_load_align (
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  ltype,
    input  logic [7:0]  store_byte,
    output logic [31:0] load_data,
    output logic [31:0] merged
);
    import mips_mem_pkg::*;

    logic [7:0] sel;

    always_comb begin
        sel    = word[7:0];
        merged = word;
        case (lane)
            2'd0: begin sel = word[7:0];   merged[7:0]   = store_byte; end
            2'd1: begin sel = word[15:8];  merged[15:8]  = store_byte; end
            2'd2: begin sel = word[23:16]; merged[23:16] = store_byte; end
            default: begin sel = word[31:24]; merged[31:24] = store_byte; end
        endcase

        case (ltype)
            LT_BYTEU: load_data = {24'b0, sel};
            LT_BYTES: load_data = {{24{sel[7]}}, sel};
            default:  load_data = word;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word-organised unified RAM behind a valid/ready
// request channel and a valid/ready response channel, with a fixed wait
// latency per access.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high; RAM contents are not cleared
//   bus     : request/response channel (slave side)
//   state_o : current FSM state (IDLE=0, WAIT=1, RESP=2)
module mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_responder_if.slave    bus,
    output logic [1:0]        state_o
);
    import mips_mem_pkg::*;

    memstate_t          state, state_nx;
    logic [CNT_W-1:0]   cnt;

    logic [ADDR_W-1:0]  idx_q;
    logic [1:0]         lane_q;
    logic [1:0]         wtype_q;
    logic [1:0]         ltype_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               err_q;

    logic [31:0]        ram [2**ADDR_W];

    logic [31:0]        word_rd, load_data, merged;
    logic               accept, access, is_read, misaligned, do_write;
    logic               unused_addr_hi;

    assign accept     = (state == IDLE) && bus.req_valid;
    assign access     = (state == WAIT) && (cnt == '0);
    assign is_read    = is_load(wtype_q);
    // Byte loads/stores can never be misaligned; only word-sized accesses check the lane
    assign misaligned = (lane_q != 2'd0) &&
                        ((wtype_q == MW_WORD) ||
                         (is_read && ltype_q != LT_BYTEU && ltype_q != LT_BYTES));
    assign do_write   = access && !is_read && !misaligned;
    assign word_rd    = ram[idx_q];

    // Upper address bits wrap; they are intentionally unused
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    mem_load_align u_align (
        .word       (word_rd),
        .lane       (lane_q),
        .ltype      (ltype_q),
        .store_byte (wdata_q[7:0]),
        .load_data  (load_data),
        .merged     (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.req_valid)  state_nx = WAIT;
            WAIT:    if (cnt == '0)      state_nx = RESP;
            RESP:    if (bus.rsp_ready)  state_nx = IDLE;
            default:                     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            wtype_q <= '0;
            ltype_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                idx_q   <= bus.req_addr[ADDR_W+1:2];
                lane_q  <= bus.req_addr[1:0];
                wtype_q <= bus.req_wtype;
                ltype_q <= bus.req_ltype;
                wdata_q <= bus.req_wdata;
                cnt     <= CNT_W'(LATENCY - 1);
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (access) begin
                rdata_q <= (is_read && !misaligned) ? load_data : '0;
                err_q   <= misaligned;
            end
        end
    end

    // Stores commit only on the WAIT->RESP edge; reset leaves state IDLE so an abandoned store never lands
    always_ff @(posedge clk) begin
        if (do_write) ram[idx_q] <= (wtype_q == MW_WORD) ? wdata_q : merged;
    end

    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign state_o       = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 2, 1, 15) share one request
// stream; a word-level memory model predicts every response and the expected
// cycle at which each instance presents it.
module tb_mem_responder;

    localparam int NI = 3;

    function automatic int lat_of(input int k);
        case (k)
            0: return 2;
            1: return 1;
            default: return 15;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_wtype, req_ltype;

    always #5 clk = ~clk;

    mem_responder_if bus0();
    mem_responder_if bus1();
    mem_responder_if bus2();

    assign bus0.req_valid = req_valid; assign bus1.req_valid = req_valid; assign bus2.req_valid = req_valid;
    assign bus0.req_addr  = req_addr;  assign bus1.req_addr  = req_addr;  assign bus2.req_addr  = req_addr;
    assign bus0.req_wtype = req_wtype; assign bus1.req_wtype = req_wtype; assign bus2.req_wtype = req_wtype;
    assign bus0.req_ltype = req_ltype; assign bus1.req_ltype = req_ltype; assign bus2.req_ltype = req_ltype;
    assign bus0.req_wdata = req_wdata; assign bus1.req_wdata = req_wdata; assign bus2.req_wdata = req_wdata;
    assign bus0.rsp_ready = rsp_ready; assign bus1.rsp_ready = rsp_ready; assign bus2.rsp_ready = rsp_ready;

    logic [1:0] st0, st1, st2;

    mem_responder #(.ADDR_W(8), .LATENCY(2))  dut0 (.clk(clk), .reset(reset), .bus(bus0), .state_o(st0));
    mem_responder #(.ADDR_W(8), .LATENCY(1))  dut1 (.clk(clk), .reset(reset), .bus(bus1), .state_o(st1));
    mem_responder #(.ADDR_W(8), .LATENCY(15)) dut2 (.clk(clk), .reset(reset), .bus(bus2), .state_o(st2));

    logic [NI-1:0] rq, rv, er;
    logic [31:0]   rd [NI];
    logic [1:0]    st [NI];

    assign rq = {bus2.req_ready, bus1.req_ready, bus0.req_ready};
    assign rv = {bus2.rsp_valid, bus1.rsp_valid, bus0.rsp_valid};
    assign er = {bus2.rsp_err,   bus1.rsp_err,   bus0.rsp_err};
    assign rd[0] = bus0.rsp_rdata; assign rd[1] = bus1.rsp_rdata; assign rd[2] = bus2.rsp_rdata;
    assign st[0] = st0; assign st[1] = st1; assign st[2] = st2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst%0d got=%h want=%h t=%0t", name, k, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0] mem [256];

    bit        txn_active = 0;
    bit        chk_on     = 0;
    bit [31:0] exp_rd;
    bit        exp_err;
    bit        exp_wr;
    bit [7:0]  exp_idx;
    bit [31:0] exp_new;
    logic [31:0] last_rd  [NI];
    logic        last_err [NI];

    task automatic model_access(input bit [1:0] wt, input bit [1:0] lt, input bit [31:0] addr,
                                input bit [31:0] wdata);
        bit [31:0] w;
        bit [1:0]  lane;
        bit [7:0]  b;
        bit [31:0] mask;
        idx_and_lane: begin
            exp_idx = addr[9:2];
            lane    = addr[1:0];
        end
        w       = mem[exp_idx];
        exp_rd  = 0;
        exp_err = 0;
        exp_wr  = 0;
        exp_new = w;
        if (wt == 2'b01) begin
            if (lane != 0) exp_err = 1;
            else begin exp_wr = 1; exp_new = wdata; end
        end else if (wt == 2'b10) begin
            mask    = 32'hFF << (8 * lane);
            exp_new = (w & ~mask) | ({24'b0, wdata[7:0]} << (8 * lane));
            exp_wr  = 1;
        end else begin
            b = 8'(w >> (8 * lane));
            if (lt == 2'b01)      exp_rd = {24'b0, b};
            else if (lt == 2'b10) exp_rd = 32'($signed(b));
            else if (lane != 0)   exp_err = 1;
            else                  exp_rd = w;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        int  n    = 0;
        bit  prev = 0;
        bit  want_v;
        forever begin
            @(negedge clk);
            if (txn_active) n = prev ? n + 1 : 0;
            prev = txn_active;
            if (chk_on) begin
                for (int k = 0; k < NI; k++) begin
                    if (txn_active) begin
                        want_v = (n >= lat_of(k));
                        chk("req_ready_busy", k, 32'(rq[k]), 32'd0);
                        chk("rsp_valid", k, 32'(rv[k]), 32'(want_v));
                        chk("state_busy", k, 32'(st[k]), want_v ? 32'd2 : 32'd1);
                        if (want_v) begin
                            chk("rsp_rdata", k, rd[k], exp_rd);
                            chk("rsp_err", k, 32'(er[k]), 32'(exp_err));
                        end
                    end else begin
                        chk("req_ready_idle", k, 32'(rq[k]), 32'd1);
                        chk("rsp_valid_idle", k, 32'(rv[k]), 32'd0);
                        chk("state_idle", k, 32'(st[k]), 32'd0);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic start_txn(input bit [1:0] wt, input bit [1:0] lt, input bit [31:0] addr,
                             input bit [31:0] wdata);
        int g = 0;
        model_access(wt, lt, addr, wdata);
        do begin @(negedge clk); g++; end while (rq !== '1 && g < 50);
        if (rq !== '1) begin
            total++; bad++;
            $display("FAIL ready_timeout got=%b want=111", rq);
        end
        req_valid = 1'b1;
        req_wtype = wt;
        req_ltype = lt;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        txn_active = 1;
        #1;
        // Keep a request asserted with junk fields while busy; it must be ignored
        req_wtype = 2'($urandom);
        req_ltype = 2'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic finish_txn(input int hold);
        int g = 0;
        do begin @(negedge clk); g++; end while (rv !== '1 && g < 40);
        if (rv !== '1) begin
            total++; bad++;
            $display("FAIL rsp_timeout got=%b want=111", rv);
        end
        for (int k = 0; k < NI; k++) begin
            last_rd[k]  = rd[k];
            last_err[k] = er[k];
        end
        repeat (hold) @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        txn_active = 0;
        if (exp_wr) mem[exp_idx] = exp_new;
        #1 rsp_ready = 1'b0;
    endtask

    task automatic txn(input bit [1:0] wt, input bit [1:0] lt, input bit [31:0] addr,
                       input bit [31:0] wdata, input int hold);
        start_txn(wt, lt, addr, wdata);
        finish_txn(hold);
    endtask

    task automatic chk_last(input string name, input logic [31:0] want_rd, input logic want_err);
        for (int k = 0; k < NI; k++) begin
            chk({name, "_rdata"}, k, last_rd[k], want_rd);
            chk({name, "_err"}, k, 32'(last_err[k]), 32'(want_err));
        end
    endtask

    initial begin
        bit [31:0] init4;
        reset     = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wtype = '0;
        req_ltype = '0;
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_req_ready", k, 32'(rq[k]), 32'd1);
            chk("rst_rsp_valid", k, 32'(rv[k]), 32'd0);
            chk("rst_rdata", k, rd[k], 32'd0);
            chk("rst_err", k, 32'(er[k]), 32'd0);
            chk("rst_state", k, 32'(st[k]), 32'd0);
        end
        reset = 1'b0;
        chk_on = 1;

        // Fill the working region (words 0..15) so every later load is defined
        for (int w = 0; w < 16; w++) txn(2'b01, 2'b00, 32'(w * 4), $urandom, 0);
        init4 = mem[4];

        // Reset in the middle of a store's WAIT: the store must not commit
        start_txn(2'b01, 2'b00, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        #2;
        reset      = 1'b1;
        txn_active = 0;
        req_valid  = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("midrst_req_ready", k, 32'(rq[k]), 32'd1);
            chk("midrst_rsp_valid", k, 32'(rv[k]), 32'd0);
            chk("midrst_state", k, 32'(st[k]), 32'd0);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        txn(2'b00, 2'b00, 32'h10, 0, 0);
        chk_last("rst_no_commit", init4, 1'b0);

        txn(2'b01, 2'b00, 32'h20, 32'h12345678, 0);
        chk_last("sw", 32'd0, 1'b0);
        txn(2'b00, 2'b00, 32'h20, 0, 0);
        chk_last("lw", 32'h12345678, 1'b0);
        txn(2'b10, 2'b00, 32'h21, 32'h555555AB, 1);
        txn(2'b00, 2'b00, 32'h20, 0, 0);
        chk_last("sb_lw", 32'h1234AB78, 1'b0);
        txn(2'b00, 2'b10, 32'h21, 0, 0);
        chk_last("lb", 32'hFFFFFFAB, 1'b0);
        txn(2'b00, 2'b01, 32'h21, 0, 0);
        chk_last("lbu", 32'h000000AB, 1'b0);
        txn(2'b00, 2'b00, 32'h22, 0, 0);
        chk_last("lw_mis", 32'd0, 1'b1);
        txn(2'b01, 2'b00, 32'h23, 32'hCAFEF00D, 0);
        chk_last("sw_mis", 32'd0, 1'b1);
        txn(2'b00, 2'b00, 32'h20, 0, 5);
        chk_last("sw_mis_lw_bp", 32'h1234AB78, 1'b0);
        txn(2'b01, 2'b00, 32'h400, 32'h0BADF00D, 0);
        txn(2'b00, 2'b00, 32'h000, 0, 0);
        chk_last("wrap", 32'h0BADF00D, 1'b0);

        for (int i = 0; i < 200; i++) begin
            bit [31:0] a;
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            txn(2'($urandom), 2'($urandom), a, $urandom, $urandom_range(0, 3));
        end

        @(negedge clk);
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
